softmax_sched: RTL and testbench

Round-robin job scheduler that shares one softmax engine among NREQ requesters. Each requester submits a job of N rows; the scheduler arbitrates, then issues the rows to the engine one at a time with a start/done handshake. It guards each row with a timeout and returns a one-cycle completion pulse, with an error flag, to the owning requester. It sits between the attention-head controllers and the softmax datapath.

---
 rtl/softmax_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/softmax_sched.sv | 117 +++++++++++
 tb/tb_softmax_sched.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared types and defaults for the softmax job scheduler.
package softmax_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        CMPL  = 2'd3
    } sched_state_t;

    localparam int NREQ_DEF    = 4;
    localparam int ROW_W_DEF   = 8;
    localparam int TIMEOUT_DEF = 1024;

    // Width of a requester index; at least one bit so a port always exists.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ENG_SEL_W = sel_width(NREQ_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above rr_ptr, wrapping.
module rr_arbiter
    import softmax_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]            req,
    input  logic [sel_width(NREQ)-1:0] rr_ptr,
    output logic [NREQ-1:0]            grant,
    output logic [sel_width(NREQ)-1:0] idx
);

    localparam int SEL_W = sel_width(NREQ);

    // NOTE: every output of a combinational block gets a default before any branch, otherwise a latch is inferred.
    always_comb begin
        int   j;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(rr_ptr) + i) % NREQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = SEL_W'(j);
            end
        end
    end

endmodule

// File: rtl/softmax_sched.sv
// Shares one softmax engine among NREQ requesters: arbitrates whole jobs, issues rows
// one at a time with a per-row timeout, and returns a completion pulse to the owner.
module softmax_sched
    import softmax_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int ROW_W   = ROW_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*ROW_W-1:0]      req_rows,
    output logic [NREQ-1:0]            req_ready,
    output logic                       eng_start,
    output logic [ROW_W-1:0]           eng_row,
    output logic [sel_width(NREQ)-1:0] eng_sel,
    input  logic                       eng_done,
    output logic [NREQ-1:0]            cmpl_valid,
    output logic                       cmpl_err,
    output logic                       busy
);

    localparam int SEL_W = sel_width(NREQ);
    localparam int TMR_W = $clog2(TIMEOUT);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_CMPL  = CMPL;

    logic [1:0]       state;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] win_idx;
    logic [NREQ-1:0]  win_grant;
    logic [ROW_W-1:0] win_rows;
    logic [ROW_W-1:0] rows;
    logic [ROW_W-1:0] row_cnt;
    logic [TMR_W-1:0] timer;
    logic             err;
    logic             last_row;
    logic             timed_out;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (win_grant),
        .idx    (win_idx)
    );

    assign win_rows  = req_rows[int'(win_idx)*ROW_W +: ROW_W];
    assign last_row  = (row_cnt == rows - ROW_W'(1));
    assign timed_out = (timer == TMR_W'(TIMEOUT - 1));

    // The grant is offered only while idle, so the handshake always lands in IDLE.
    assign req_ready = (state == ST_IDLE) ? win_grant : '0;
    assign eng_start = (state == ST_ISSUE);
    assign eng_row   = row_cnt;
    assign cmpl_err  = (state == ST_CMPL) & err;
    assign busy      = (state != ST_IDLE);

    always_comb begin
        cmpl_valid = '0;
        if (state == ST_CMPL) cmpl_valid[eng_sel] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            eng_sel <= '0;
            rows    <= '0;
            row_cnt <= '0;
            timer   <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|win_grant) begin
                        eng_sel <= win_idx;
                        rows    <= win_rows;
                        row_cnt <= '0;
                        err     <= 1'b0;
                        state   <= (win_rows == '0) ? ST_CMPL : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving on the last timer cycle beats the timeout.
                    if (eng_done) begin
                        if (last_row) begin
                            state <= ST_CMPL;
                        end else begin
                            row_cnt <= row_cnt + ROW_W'(1);
                            state   <= ST_ISSUE;
                        end
                    end else if (timed_out) begin
                        err   <= 1'b1;
                        state <= ST_CMPL;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_CMPL: begin
                    rr_ptr <= (eng_sel == SEL_W'(NREQ - 1)) ? '0 : eng_sel + SEL_W'(1);
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_sched.sv
// Directed bench for softmax_sched: cycle-level reference model plus hand-computed event checks.
module tb_softmax_sched;

    localparam int NREQ    = 4;
    localparam int ROW_W   = 8;
    localparam int TIMEOUT = 8;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*ROW_W-1:0] req_rows;
    logic [NREQ-1:0]       req_ready;
    logic                  eng_start;
    logic [ROW_W-1:0]      eng_row;
    logic [1:0]            eng_sel;
    logic                  eng_done;
    logic [NREQ-1:0]       cmpl_valid;
    logic                  cmpl_err;
    logic                  busy;

    softmax_sched #(.NREQ(NREQ), .ROW_W(ROW_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_rows   (req_rows),
        .req_ready  (req_ready),
        .eng_start  (eng_start),
        .eng_row    (eng_row),
        .eng_sel    (eng_sel),
        .eng_done   (eng_done),
        .cmpl_valid (cmpl_valid),
        .cmpl_err   (cmpl_err),
        .busy       (busy)
    );

    typedef struct {
        int cyc;
        int val;
        int err;
    } ev_t;

    ev_t gq[$];
    ev_t sq[$];
    ev_t cq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int eng_lat = 0;
    int pend    = 0;
    bit spur    = 1'b0;

    // Reference model: job-level view driven by the timing rules.
    bit m_active   = 1'b0;
    int m_rr       = 0;
    int m_owner    = 0;
    int m_rows     = 0;
    int m_row      = 0;
    int m_start_at = -1;
    int m_cmpl_at  = -1;
    int m_err      = 0;
    int m_wait_s   = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int qsize(input int kind);
        if (kind == 0) return gq.size();
        if (kind == 1) return sq.size();
        return cq.size();
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_q(input int kind, input int target, input int budget, input string name);
        int n;
        n = 0;
        while (qsize(kind) < target && n < budget) begin
            tick();
            n++;
        end
        if (qsize(kind) < target) check(name, qsize(kind), target);
    endtask

    task automatic set_rows(input int r0, input int r1, input int r2, input int r3);
        req_rows = {ROW_W'(r3), ROW_W'(r2), ROW_W'(r1), ROW_W'(r0)};
    endtask

    // Engine stand-in: done eng_lat cycles after each start (never if eng_lat==0), plus injected strays.
    initial begin
        eng_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && eng_start && eng_lat > 0) pend = eng_lat;
            @(posedge clk);
            #2;
            eng_done = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) eng_done = 1'b1;
            end
            if (spur) begin
                eng_done = 1'b1;
                spur     = 1'b0;
            end
        end
    end

    // Per-cycle compare against the model, plus event logging of what the DUT did.
    always @(negedge clk) begin
        logic [NREQ-1:0] e_ready;
        logic [NREQ-1:0] e_cmpl;
        logic            e_start;
        logic            e_err;
        int              w;
        if (!rst_n) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_eng_start", eng_start, 0);
            check("rst_cmpl_valid", cmpl_valid, 0);
            check("rst_busy", busy, 0);
            m_active   = 1'b0;
            m_rr       = 0;
            m_start_at = -1;
            m_cmpl_at  = -1;
            m_wait_s   = -1;
        end else begin
            e_ready = '0;
            w       = -1;
            if (!m_active) begin
                for (int k = 0; k < NREQ; k++) begin
                    int c;
                    c = (m_rr + k) % NREQ;
                    if (w < 0 && req_valid[c]) w = c;
                end
            end
            if (w >= 0) e_ready[w] = 1'b1;
            e_start = m_active && (cyc == m_start_at);
            e_cmpl  = '0;
            e_err   = 1'b0;
            if (m_active && cyc == m_cmpl_at) begin
                e_cmpl[m_owner] = 1'b1;
                e_err           = (m_err != 0);
            end

            check("req_ready", req_ready, e_ready);
            check("eng_start", eng_start, e_start);
            check("cmpl_valid", cmpl_valid, e_cmpl);
            check("cmpl_err", cmpl_err, e_err);
            check("busy", busy, m_active);
            if (m_active) check("eng_sel", eng_sel, m_owner);
            if (e_start) check("eng_row", eng_row, m_row);

            if (|req_ready) gq.push_back('{cyc, onehot_idx(req_ready), 0});
            if (eng_start) sq.push_back('{cyc, int'(eng_row), 0});
            if (|cmpl_valid) cq.push_back('{cyc, onehot_idx(cmpl_valid), int'(cmpl_err)});

            if (w >= 0) begin
                m_active = 1'b1;
                m_owner  = w;
                m_rows   = int'(req_rows[w*ROW_W +: ROW_W]);
                m_row    = 0;
                m_wait_s = -1;
                m_err    = 0;
                if (m_rows == 0) begin
                    m_cmpl_at  = cyc + 1;
                    m_start_at = -1;
                end else begin
                    m_start_at = cyc + 1;
                    m_cmpl_at  = -1;
                end
            end else if (m_active) begin
                if (cyc == m_start_at) begin
                    m_wait_s = cyc;
                end else if (m_wait_s >= 0 && cyc > m_wait_s && cyc <= m_wait_s + TIMEOUT) begin
                    if (eng_done) begin
                        m_wait_s = -1;
                        if (m_row == m_rows - 1) begin
                            m_cmpl_at = cyc + 1;
                            m_err     = 0;
                        end else begin
                            m_row++;
                            m_start_at = cyc + 1;
                        end
                    end else if (cyc == m_wait_s + TIMEOUT) begin
                        m_wait_s  = -1;
                        m_cmpl_at = cyc + 1;
                        m_err     = 1;
                    end
                end else if (cyc == m_cmpl_at) begin
                    m_active = 1'b0;
                    m_rr     = (m_owner + 1) % NREQ;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gb;
        int sb;
        int cb;
        int t0;
        rst_n     = 1'b0;
        req_valid = '0;
        set_rows(0, 0, 0, 0);
        repeat (3) tick();
        check("reset_req_ready", req_ready, 0);
        check("reset_eng_start", eng_start, 0);
        check("reset_eng_row", eng_row, 0);
        check("reset_eng_sel", eng_sel, 0);
        check("reset_cmpl", cmpl_valid, 0);
        check("reset_cmpl_err", cmpl_err, 0);
        check("reset_busy", busy, 0);
        #2 rst_n = 1'b1;
        tick();

        // Fairness: everyone holds valid, one row each; expect 0,1,2,3,0.
        gb = gq.size();
        eng_lat   = 2;
        set_rows(1, 1, 1, 1);
        req_valid = 4'b1111;
        wait_q(0, gb + 5, 200, "fair_grants");
        req_valid = '0;
        wait_q(2, gb + 5, 50, "fair_cmpls");
        if (gq.size() >= gb + 5) begin
            for (int i = 0; i < 5; i++) check($sformatf("fair_order_%0d", i), gq[gb+i].val, i % NREQ);
            check("fair_spacing", gq[gb+1].cyc - gq[gb].cyc, 5);
        end
        tick();

        // Single job: requester 2, three rows, engine latency 4.
        gb = gq.size(); sb = sq.size(); cb = cq.size();
        eng_lat = 4;
        set_rows(0, 0, 3, 0);
        req_valid = 4'b0100;
        wait_q(0, gb + 1, 20, "single_grant");
        req_valid = '0;
        wait_q(2, cb + 1, 100, "single_cmpl");
        if (gq.size() > gb && sq.size() >= sb + 3 && cq.size() > cb) begin
            t0 = gq[gb].cyc;
            check("single_grant_idx", gq[gb].val, 2);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("single_start_cyc_%0d", i), sq[sb+i].cyc - t0, 1 + 5*i);
                check($sformatf("single_start_row_%0d", i), sq[sb+i].val, i);
            end
            check("single_cmpl_cyc", cq[cb].cyc - t0, 16);
            check("single_cmpl_idx", cq[cb].val, 2);
            check("single_cmpl_err", cq[cb].err, 0);
        end
        tick();

        // Zero rows: no engine start, completion the cycle after the handshake.
        gb = gq.size(); sb = sq.size(); cb = cq.size();
        set_rows(0, 0, 0, 0);
        req_valid = 4'b0010;
        wait_q(0, gb + 1, 20, "zero_grant");
        req_valid = '0;
        wait_q(2, cb + 1, 20, "zero_cmpl");
        if (gq.size() > gb && cq.size() > cb) begin
            check("zero_cmpl_cyc", cq[cb].cyc - gq[gb].cyc, 1);
            check("zero_cmpl_idx", cq[cb].val, 1);
            check("zero_cmpl_err", cq[cb].err, 0);
            check("zero_no_start", sq.size(), sb);
        end
        tick();

        // Timeout: engine silent; requester 3 wins from rr_ptr=2, then requester 0 follows.
        gb = gq.size(); sb = sq.size(); cb = cq.size();
        eng_lat = 0;
        set_rows(1, 0, 0, 2);
        req_valid = 4'b1001;
        wait_q(0, gb + 1, 20, "tmo_grant");
        req_valid = 4'b0001;
        wait_q(2, cb + 1, 50, "tmo_cmpl");
        eng_lat = 3;
        wait_q(0, gb + 2, 20, "tmo_next_grant");
        req_valid = '0;
        wait_q(2, cb + 2, 50, "tmo_next_cmpl");
        if (gq.size() >= gb + 2 && cq.size() >= cb + 2) begin
            check("tmo_grant_idx", gq[gb].val, 3);
            check("tmo_cmpl_cyc", cq[cb].cyc - gq[gb].cyc, 10);
            check("tmo_cmpl_err", cq[cb].err, 1);
            check("tmo_one_start", sq.size() - sb, 2);
            check("tmo_next_idx", gq[gb+1].val, 0);
            check("tmo_next_cyc", gq[gb+1].cyc - cq[cb].cyc, 1);
            check("tmo_next_err", cq[cb+1].err, 0);
        end
        tick();

        // Done on the last timer cycle wins over the timeout.
        gb = gq.size(); sb = sq.size(); cb = cq.size();
        eng_lat = TIMEOUT;
        set_rows(0, 2, 0, 0);
        req_valid = 4'b0010;
        wait_q(0, gb + 1, 20, "coll_grant");
        req_valid = '0;
        wait_q(2, cb + 1, 60, "coll_cmpl");
        if (gq.size() > gb && sq.size() >= sb + 2 && cq.size() > cb) begin
            t0 = gq[gb].cyc;
            check("coll_start1_cyc", sq[sb+1].cyc - t0, 10);
            check("coll_start1_row", sq[sb+1].val, 1);
            check("coll_cmpl_cyc", cq[cb].cyc - t0, 19);
            check("coll_cmpl_err", cq[cb].err, 0);
        end

        // Stray eng_done while idle must not wake the scheduler.
        sb = sq.size();
        tick();
        tick();
        spur = 1'b1;
        tick();
        tick();
        check("spur_busy", busy, 0);
        check("spur_no_start", sq.size(), sb);

        // Reset during WAIT of row 2 of a five-row job.
        gb = gq.size(); sb = sq.size(); cb = cq.size();
        eng_lat = 4;
        set_rows(0, 0, 5, 0);
        req_valid = 4'b0100;
        wait_q(0, gb + 1, 20, "rst_grant");
        req_valid = '0;
        wait_q(1, sb + 3, 40, "rst_row2_start");
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_eng_sel", eng_sel, 0);
        check("midrst_eng_row", eng_row, 0);
        check("midrst_eng_start", eng_start, 0);
        check("midrst_cmpl", cmpl_valid, 0);
        tick();
        tick();
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        gb = gq.size();
        eng_lat = 2;
        set_rows(0, 1, 0, 1);
        req_valid = 4'b1010;
        wait_q(0, gb + 1, 20, "post_rst_grant");
        req_valid = '0;
        wait_q(2, cb + 1, 30, "post_rst_cmpl");
        if (gq.size() > gb && cq.size() > cb) begin
            check("post_rst_grant_idx", gq[gb].val, 1);
            check("post_rst_cmpl_idx", cq[cb].val, 1);
        end
        tick();
        tick();
        check("post_rst_cmpl_count", cq.size() - cb, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
